sim_io_console: RTL and testbench
=================================

// Module: sim_io_console
// PURPOSE
//  Memory-mapped console/halt endpoint directly downstream of riscv_top's CPU memory port.
//  Consumes CPU byte writes to the I/O window (0x30000 base).
//  Buffers output characters in a FIFO and drains them over a valid/ready byte stream.
//  On a halt write, flushes the FIFO, then raises halt_req so the simulation top can $finish.
// PARAMETERS
//  FIFO_DEPTH  16  output FIFO entries; power of two, >=4
//  FULL_MARGIN 2   io_buffer_full asserts when free entries <= FULL_MARGIN (CPU issue slack)
// PORTS
//  clk_in          in   1   system clock; all state on posedge
//  rst_in          in   1   reset; asynchronous assert, active-low (0 = reset)
//  rdy_in          in   1   global ready; when 0, no CPU-side state changes (tx drain continues)
//  io_en           in   1   CPU access targets I/O window this cycle
//  io_wr           in   1   1 = write, 0 = read (qualified by io_en)
//  io_addr         in   3   byte offset within I/O window
//  io_din          in   8   write data
//  io_dout         out  8   read data, registered (valid cycle after read)
//  io_buffer_full  out  1   CPU must not issue console writes while high
//  tx_valid        out  1   head-of-FIFO byte valid
//  tx_data         out  8   head-of-FIFO byte
//  tx_ready        in   1   consumer accepts byte when tx_valid & tx_ready
//  halt_req        out  1   sticky; simulation finished
//  halt_code       out  8   byte written with the halt command
//  cycle_count     out  32  cycles since reset release while rdy_in=1
// BEHAVIOUR
//  Reset (rst_in=0, async): FIFO empty, count=0, state=RUN.
//   io_dout=0, tx_valid=0, tx_data=0, io_buffer_full=0, halt_req=0, halt_code=0, cycle_count=0.
//  Address map; qualified by io_en & rdy_in:
//   0x0 W: push io_din into FIFO.
//   0x0 R: io_dout = {7'b0, fifo_empty}.
//   0x4 W: halt command; halt_code <= io_din; state RUN->DRAIN.
//   0x4 R: io_dout = count (saturating at 8 bits).
//   0x5 R: cycle_count[7:0]; 0x6 R: [15:8]; 0x7 R: [23:16].
//   Other offsets: writes ignored; reads return 0.
//  Read latency 1 cycle: io_dout updates on the edge after the read. It holds its value otherwise.
//  FIFO:
//   - Push and pop in the same cycle -> count unchanged, data order preserved.
//   - Pointers wrap modulo FIFO_DEPTH.
//   - Push when count==FIFO_DEPTH -> byte dropped, no state corruption.
//   - tx_valid = !empty; tx_data = mem[rd_ptr] (combinational from registered storage).
//   - Pop on tx_valid & tx_ready, independent of rdy_in.
//  io_buffer_full is registered and asserted when FIFO_DEPTH-count_next <= FULL_MARGIN.
//  FSM:
//   RUN   -> DRAIN on halt write.
//   DRAIN -> HALT when FIFO empty (incl. empty at entry, 1 cycle).
//   HALT  is terminal until reset; halt_req=1 in HALT only.
//  In DRAIN/HALT:
//   - Console writes (0x0) are dropped.
//   - Further halt writes are ignored; halt_code keeps its first value.
//   - Reads still serviced.
//  Simultaneous console push and halt write cannot occur: one access per cycle.
//  cycle_count increments every cycle with rdy_in=1 and state!=HALT; wraps at 2^32.
//  Reset mid-DRAIN or mid-transfer:
//   - Queued bytes are discarded; tx_valid drops asynchronously.
//   - A byte presented with tx_valid at assertion is not considered sent.
// TESTING
//  1 Reset: hold rst_in=0 with io_en pulses -> all outputs 0.
//    Release -> cycle_count=1 one edge later (rdy_in=1).
//  2 Write 'H','i' to 0x0, tx_ready=1 -> tx_data 0x48 then 0x69, consecutive cycles.
//    Then tx_valid=0; read 0x0 -> io_dout=1 next cycle.
//  3 tx_ready=0, push 14 bytes (DEPTH 16) -> io_buffer_full=1 after 14th.
//    Push 16th and 17th -> 17th dropped; drain yields exactly 16 bytes in order.
//  4 Push 3 bytes, tx_ready=0, write 0x4 <- 0x00 -> halt_req stays 0.
//    tx_ready=1 -> 3 bytes out, halt_req=1 the cycle after FIFO empty, halt_code=0x00.
//  5 In HALT, write 0x0 <- 'X' and 0x4 <- 0x55 -> no tx_valid; halt_code stays 0x00.
//    cycle_count frozen.
//  6 Fill 5 bytes, in DRAIN, pulse rst_in=0 mid-cycle -> tx_valid=0 and halt_req=0 immediately.
//    After release, FIFO empty, state RUN.

Source files
------------

// File: rtl/sim_io_console.sv
// Console/halt endpoint on the CPU I/O window: buffers console bytes in a FIFO,
// streams them out over valid/ready, and raises a sticky halt once drained.
module sim_io_console #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        io_en,
    input  logic        io_wr,
    input  logic [2:0]  io_addr,
    input  logic [7:0]  io_din,
    output logic [7:0]  io_dout,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt_req,
    output logic [7:0]  halt_code,
    output logic [31:0] cycle_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            cpu_acc, push, pop, halt_wr, fifo_empty;
    logic [7:0]      rd_data;

    function automatic logic [7:0] sat8(input logic [CW-1:0] c);
        logic [31:0] w;
        w = 32'(c);
        return (w > 32'd255) ? 8'hFF : w[7:0];
    endfunction

    function automatic logic near_full(input logic [CW-1:0] c);
        return (CW'(FIFO_DEPTH) - c) <= CW'(FULL_MARGIN);
    endfunction

    assign cpu_acc    = io_en & rdy_in;
    assign fifo_empty = (count == '0);
    assign push       = cpu_acc & io_wr & (io_addr == 3'd0) & (state_q == ST_RUN)
                        & (count != CW'(FIFO_DEPTH));
    assign halt_wr    = cpu_acc & io_wr & (io_addr == 3'd4) & (state_q == ST_RUN);
    // Drain side runs regardless of rdy_in so the consumer is never stalled by the CPU.
    assign pop        = tx_valid & tx_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : mem[rd_ptr];
    assign halt_req = (state_q == ST_HALT);

    always_comb begin
        rd_data = 8'h00;
        case (io_addr)
            3'd0:    rd_data = {7'b0, fifo_empty};
            3'd4:    rd_data = sat8(count);
            3'd5:    rd_data = cycle_count[7:0];
            3'd6:    rd_data = cycle_count[15:8];
            3'd7:    rd_data = cycle_count[23:16];
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (halt_wr) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_d = ST_HALT;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= ST_RUN;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            io_dout        <= 8'h00;
            halt_code      <= 8'h00;
            cycle_count    <= 32'd0;
        end else begin
            state_q        <= state_d;
            count          <= count_next;
            io_buffer_full <= near_full(count_next);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (cpu_acc && !io_wr) io_dout <= rd_data;
            if (halt_wr) halt_code <= io_din;
            if (rdy_in && state_q != ST_HALT) cycle_count <= cycle_count + 32'd1;
        end
    end

    // Storage holds data only; validity comes from count, so no reset is needed here.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= io_din;
    end

endmodule

// File: tb/tb_sim_io_console.sv
// Bench for sim_io_console: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_sim_io_console;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_en, io_wr, tx_ready;
    logic [2:0]  io_addr;
    logic [7:0]  io_din;
    logic [7:0]  io_dout, tx_data, halt_code;
    logic        io_buffer_full, tx_valid, halt_req;
    logic [31:0] cycle_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0]  m_q[$];
    int          m_st;   // 0 running, 1 draining, 2 halted
    logic [31:0] m_cyc;
    logic [7:0]  m_hcode, m_dout;
    logic        m_full;
    logic [31:0] frozen;

    sim_io_console #(.FIFO_DEPTH(16), .FULL_MARGIN(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .io_en(io_en), .io_wr(io_wr), .io_addr(io_addr), .io_din(io_din),
        .io_dout(io_dout), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .halt_req(halt_req), .halt_code(halt_code), .cycle_count(cycle_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_q.delete();
        m_st = 0; m_cyc = 0; m_hcode = 0; m_dout = 0; m_full = 0;
    endtask

    task automatic m_step();
        int   n;
        logic acc, pop, push;
        n    = m_q.size();
        acc  = io_en && rdy_in;
        pop  = (n > 0) && tx_ready;
        push = acc && io_wr && io_addr == 3'd0 && m_st == 0 && n < 16;
        if (acc && !io_wr) begin
            case (io_addr)
                3'd0:    m_dout = (n == 0) ? 8'd1 : 8'd0;
                3'd4:    m_dout = (n > 255) ? 8'd255 : 8'(n);
                3'd5:    m_dout = m_cyc[7:0];
                3'd6:    m_dout = m_cyc[15:8];
                3'd7:    m_dout = m_cyc[23:16];
                default: m_dout = 8'd0;
            endcase
        end
        if (rdy_in && m_st != 2) m_cyc = m_cyc + 1;
        if (m_st == 0 && acc && io_wr && io_addr == 3'd4) begin
            m_st = 1;
            m_hcode = io_din;
        end else if (m_st == 1 && n == 0) begin
            m_st = 2;
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(io_din);
        m_full = (16 - m_q.size()) <= 2;
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clk_in or negedge rst_in);
            if (!rst_in) m_clear();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            check("tx_valid", 32'(tx_valid), 32'(m_q.size() > 0));
            check("tx_data", 32'(tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            check("halt_req", 32'(halt_req), 32'(m_st == 2));
            check("halt_code", 32'(halt_code), 32'(m_hcode));
            check("cycle_count", cycle_count, m_cyc);
            check("io_buffer_full", 32'(io_buffer_full), 32'(m_full));
            check("io_dout", 32'(io_dout), 32'(m_dout));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        io_en = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
        tick();
        io_en = 1'b0; io_wr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        io_en = 1'b1; io_wr = 1'b0; io_addr = a;
        tick();
        io_en = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; io_en = 1'b0; io_wr = 1'b0;
        io_addr = 3'd0; io_din = 8'h00; tx_ready = 1'b0;
        #1 rst_in = 1'b0;

        // reset held with CPU activity
        repeat (3) begin
            io_en = 1'b1; io_wr = 1'b1; io_addr = 3'd0; io_din = 8'h41;
            tick();
            io_addr = 3'd4;
            tick();
            io_wr = 1'b0;
            tick();
        end
        io_en = 1'b0;
        check("rst_io_dout", 32'(io_dout), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_full", 32'(io_buffer_full), 32'd0);
        check("rst_halt_req", 32'(halt_req), 32'd0);
        check("rst_halt_code", 32'(halt_code), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        rst_in = 1'b1;
        tick();
        check("cycle_after_release", cycle_count, 32'd1);

        // 'H','i' stream out on consecutive cycles
        tx_ready = 1'b1;
        wr(3'd0, 8'h48);
        check("hi_valid0", 32'(tx_valid), 32'd1);
        check("hi_data0", 32'(tx_data), 32'h48);
        wr(3'd0, 8'h69);
        check("hi_valid1", 32'(tx_valid), 32'd1);
        check("hi_data1", 32'(tx_data), 32'h69);
        tick();
        check("hi_empty", 32'(tx_valid), 32'd0);
        rd(3'd0);
        check("rd_empty_flag", 32'(io_dout), 32'd1);
        rdy_in = 1'b0;
        wr(3'd0, 8'h5A);
        rdy_in = 1'b1;
        check("rdy_gated_push", 32'(tx_valid), 32'd0);

        // fill, near-full flag, overflow drop, ordered drain
        tx_ready = 1'b0;
        for (int i = 0; i < 13; i++) wr(3'd0, 8'(8'h10 + i));
        check("full_at_13", 32'(io_buffer_full), 32'd0);
        wr(3'd0, 8'h1D);
        check("full_at_14", 32'(io_buffer_full), 32'd1);
        wr(3'd0, 8'h1E);
        wr(3'd0, 8'h1F);
        wr(3'd0, 8'h20);
        rd(3'd4);
        check("count_16", 32'(io_dout), 32'd16);
        check("model_size_16", 32'(m_q.size()), 32'd16);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", 32'(tx_valid), 32'd1);
            check("drain_data", 32'(tx_data), 32'(8'h10 + i));
            tick();
        end
        check("drain_done", 32'(tx_valid), 32'd0);

        // halt waits for the FIFO to drain
        tx_ready = 1'b0;
        wr(3'd0, 8'hA1);
        wr(3'd0, 8'hA2);
        wr(3'd0, 8'hA3);
        wr(3'd4, 8'h00);
        repeat (3) tick();
        check("drain_hold_halt", 32'(halt_req), 32'd0);
        check("drain_hold_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        repeat (3) tick();
        check("drained_valid", 32'(tx_valid), 32'd0);
        check("drained_no_halt_yet", 32'(halt_req), 32'd0);
        tick();
        check("halt_req_set", 32'(halt_req), 32'd1);
        check("halt_code_00", 32'(halt_code), 32'h00);
        check("model_halted", 32'(m_st), 32'd2);

        // halted: writes ignored, counter frozen, reads serviced
        frozen = m_cyc;
        wr(3'd0, 8'h58);
        check("halt_no_push", 32'(tx_valid), 32'd0);
        wr(3'd4, 8'h55);
        check("halt_code_kept", 32'(halt_code), 32'h00);
        repeat (3) tick();
        check("cycle_frozen", cycle_count, frozen);
        rd(3'd0);
        check("halt_rd_empty", 32'(io_dout), 32'd1);
        rd(3'd5);
        check("halt_rd_cyc_lo", 32'(io_dout), 32'(frozen[7:0]));

        // reset in the middle of a drain
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        tick();
        check("rerun_halt_clear", 32'(halt_req), 32'd0);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(3'd0, 8'(8'h60 + i));
        wr(3'd4, 8'h3C);
        check("mid_drain_halt", 32'(halt_req), 32'd0);
        check("mid_drain_head", 32'(tx_data), 32'h60);
        #2 rst_in = 1'b0;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'd0);
        check("async_halt_req", 32'(halt_req), 32'd0);
        check("async_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        tick();
        check("post_rst_empty", 32'(tx_valid), 32'd0);
        rd(3'd4);
        check("post_rst_count", 32'(io_dout), 32'd0);
        tx_ready = 1'b1;
        wr(3'd0, 8'h77);
        check("post_rst_push", 32'(tx_data), 32'h77);
        wr(3'd4, 8'h3C);
        tick();
        check("second_halt", 32'(halt_req), 32'd1);
        check("second_halt_code", 32'(halt_code), 32'h3C);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
